// File: rtl/trivium_stream_cipher_if.sv
// Beat-stream bundle for the Trivium cipher: the input beat channel and the output beat channel.
interface trivium_stream_cipher_if #(
  parameter int W = 8
);
  logic         din_valid;
  logic         din_ready;
  logic [W-1:0] din_data;
  logic         dout_valid;
  logic         dout_ready;
  logic [W-1:0] dout_data;

  // master: the data source/sink around the cipher; slave: the cipher itself
  modport master (
    output din_valid, din_data, dout_ready,
    input  din_ready, dout_valid, dout_data
  );
  modport slave (
    input  din_valid, din_data, dout_ready,
    output din_ready, dout_valid, dout_data
  );
endinterface

// File: rtl/trivium_stream_cipher.sv
// Trivium 80/80 stream cipher, W keystream bits per clock; 1-clk din->dout latency, output held while dout_ready=0.
// Optional accepted-beat counter port ks_count is built when TRIVIUM_KS_COUNT_EN is defined.
module trivium_stream_cipher #(
  parameter int W           = 8,
  parameter int INIT_ROUNDS = 1152
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [79:0] key,
  input  logic [79:0] iv,
  output logic        busy,
  output logic        ks_ready,
`ifdef TRIVIUM_KS_COUNT_EN
  output logic [31:0] ks_count,
`endif
  trivium_stream_cipher_if.slave bus
);

  localparam int CW = $clog2(INIT_ROUNDS) + 1;

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  state_t         st;
  logic [287:0]   s;
  logic [287:0]   s_nxt;
  logic [W-1:0]   ks;
  logic [CW-1:0]  cnt;
  logic           accept;

  // W Trivium steps chained combinationally; s(i) lives at bit i-1.
  always_comb begin
    logic t1, t2, t3;
    s_nxt = s;
    ks    = '0;
    t1    = 1'b0;
    t2    = 1'b0;
    t3    = 1'b0;
    for (int j = 0; j < W; j++) begin
      t1    = s_nxt[65] ^ s_nxt[92];
      t2    = s_nxt[161] ^ s_nxt[176];
      t3    = s_nxt[242] ^ s_nxt[287];
      ks[j] = t1 ^ t2 ^ t3;
      t1    = t1 ^ (s_nxt[90] & s_nxt[91]) ^ s_nxt[170];
      t2    = t2 ^ (s_nxt[174] & s_nxt[175]) ^ s_nxt[263];
      t3    = t3 ^ (s_nxt[285] & s_nxt[286]) ^ s_nxt[68];
      s_nxt = {s_nxt[286:177], t2, s_nxt[175:93], t1, s_nxt[91:0], t3};
    end
  end

  // A start pulse masks ready so a simultaneous beat is never consumed by the old stream.
  assign bus.din_ready = ks_ready & ~start & (~bus.dout_valid | bus.dout_ready);
  assign accept        = bus.din_valid & bus.din_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st             <= IDLE;
      s              <= '0;
      cnt            <= '0;
      busy           <= 1'b0;
      ks_ready       <= 1'b0;
      bus.dout_valid <= 1'b0;
      bus.dout_data  <= '0;
    end else if (start) begin
      st             <= INIT;
      s              <= {3'b111, 112'b0, iv, 13'b0, key};
      cnt            <= '0;
      busy           <= 1'b1;
      ks_ready       <= 1'b0;
      bus.dout_valid <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
        end
        INIT: begin
          s   <= s_nxt;
          cnt <= cnt + CW'(W);
          if (cnt == CW'(INIT_ROUNDS - W)) begin
            st       <= RUN;
            busy     <= 1'b0;
            ks_ready <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            s              <= s_nxt;
            bus.dout_data  <= bus.din_data ^ ks;
            bus.dout_valid <= 1'b1;
          end else if (bus.dout_ready) begin
            bus.dout_valid <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef TRIVIUM_KS_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ks_count <= '0;
    end else if (start) begin
      ks_count <= '0;
    end else if (accept && ks_count != 32'hFFFF_FFFF) begin
      ks_count <= ks_count + 32'd1;
    end
  end
`else
  // Beat counter not built; accepted beats are not tallied.
`endif

endmodule

// File: tb/tb_trivium_stream_cipher.sv
// Bench for trivium_stream_cipher: W=8 and W=1 instances against a bit-serial Trivium reference.
module tb_trivium_stream_cipher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start8, start1;
  logic [79:0] key, iv;
  logic        busy8, ks8, busy1, ks1;
`ifdef TRIVIUM_KS_COUNT_EN
  logic [31:0] cnt8, cnt1;
`endif

  trivium_stream_cipher_if #(.W(8)) b8 ();
  trivium_stream_cipher_if #(.W(1)) b1 ();

  trivium_stream_cipher #(.W(8), .INIT_ROUNDS(1152)) u8 (
    .clk(clk), .reset(reset), .start(start8), .key(key), .iv(iv),
    .busy(busy8), .ks_ready(ks8),
`ifdef TRIVIUM_KS_COUNT_EN
    .ks_count(cnt8),
`endif
    .bus(b8)
  );

  trivium_stream_cipher #(.W(1), .INIT_ROUNDS(1152)) u1 (
    .clk(clk), .reset(reset), .start(start1), .key(key), .iv(iv),
    .busy(busy1), .ks_ready(ks1),
`ifdef TRIVIUM_KS_COUNT_EN
    .ks_count(cnt1),
`endif
    .bus(b1)
  );

  int checks = 0;
  int failures = 0;

  bit         mdl [0:2047];
  logic [7:0] q8[$];
  logic       q1[$];
  logic [7:0] cap8[$];
  logic       cap1[$];
  int         ptr8 = 0, ptr1 = 0, acc8 = 0, acc1 = 0;
  logic [7:0] src8 [0:63];
  logic [7:0] pt8  [0:63];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference keystream straight from the algorithm: s[1..288] as a bit array, one step at a time.
  task automatic gen_model(input logic [79:0] k, input logic [79:0] v, input int rounds, input int n);
    bit s [1:288];
    bit t1, t2, t3;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) s[i] = k[i-1];
    for (int i = 1; i <= 80; i++) s[i+93] = v[i-1];
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int step = 0; step < rounds + n; step++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      if (step >= rounds) mdl[step - rounds] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i > 178; i--) s[i] = s[i-1];
      s[178] = t2;
      for (int i = 177; i > 94; i--) s[i] = s[i-1];
      s[94] = t1;
      for (int i = 93; i > 1; i--) s[i] = s[i-1];
      s[1] = t3;
    end
  endtask

  // Scoreboard: each accepted beat queues din ^ next model word; outputs must match the queue head.
  task automatic sb_loop();
    logic [7:0] w;
    logic       b;
    forever begin
      @(negedge clk);
      if (!reset) begin
        q8.delete(); q1.delete(); ptr8 = 0; ptr1 = 0;
      end else begin
        chk("dout8_valid", 64'(b8.dout_valid), 64'(q8.size() != 0));
        if (b8.dout_valid && q8.size() != 0) begin
          chk("dout8_data", 64'(b8.dout_data), 64'(q8[0]));
          if (b8.dout_ready) begin
            cap8.push_back(b8.dout_data);
            w = q8.pop_front();
          end
        end
        if (start8) begin
          chk("start8_din_ready", 64'(b8.din_ready), 64'd0);
          q8.delete(); ptr8 = 0;
        end else if (b8.din_valid && b8.din_ready) begin
          for (int j = 0; j < 8; j++) w[j] = b8.din_data[j] ^ mdl[(ptr8 + j) % 2048];
          q8.push_back(w);
          ptr8 += 8;
          acc8++;
        end

        chk("dout1_valid", 64'(b1.dout_valid), 64'(q1.size() != 0));
        if (b1.dout_valid && q1.size() != 0) begin
          chk("dout1_data", 64'(b1.dout_data), 64'(q1[0]));
          if (b1.dout_ready) begin
            cap1.push_back(b1.dout_data[0]);
            b = q1.pop_front();
          end
        end
        if (start1) begin
          chk("start1_din_ready", 64'(b1.din_ready), 64'd0);
          q1.delete(); ptr1 = 0;
        end else if (b1.din_valid && b1.din_ready) begin
          q1.push_back(b1.din_data[0] ^ mdl[ptr1 % 2048]);
          ptr1++;
          acc1++;
        end
      end
    end
  endtask

  task automatic pulse(input bit s8, input bit s1);
    @(posedge clk); #1;
    start8 = s8; start1 = s1;
    @(posedge clk); #1;
    start8 = 1'b0; start1 = 1'b0;
  endtask

  task automatic measure_init8(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy8 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_init_cycles"}, 64'(n), 64'd144);
    chk({tag, "_ks_ready"}, 64'(ks8), 64'd1);
    chk({tag, "_busy_low"}, 64'(busy8), 64'd0);
    chk({tag, "_din_ready"}, 64'(b8.din_ready), 64'd1);
    chk({tag, "_dout_valid"}, 64'(b8.dout_valid), 64'd0);
  endtask

  task automatic stream(input int n8, input int n1);
    int base8 = acc8;
    int base1 = acc1;
    int n = 0;
    int idx;
    while ((acc8 - base8 < n8 || acc1 - base1 < n1) && n < 3000) begin
      @(posedge clk); #1;
      n++;
      idx = acc8 - base8;
      b8.din_valid = (idx < n8);
      b8.din_data  = (idx < 64) ? src8[idx] : 8'h00;
      b1.din_valid = (acc1 - base1 < n1);
      b1.din_data  = 1'b0;
    end
    chk("stream_done", 64'(n < 3000), 64'd1);
    @(posedge clk); #1;
    b8.din_valid = 1'b0;
    b1.din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [79:0] kk, vv;
    int n;
    int mism;

    reset = 1'b1; start8 = 1'b0; start1 = 1'b0;
    key = '0; iv = '0;
    b8.din_valid = 1'b0; b8.din_data = '0; b8.dout_ready = 1'b1;
    b1.din_valid = 1'b0; b1.din_data = '0; b1.dout_ready = 1'b1;

    fork
      sb_loop();
      begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
      end
    join_none

    // Model pins, worked by hand from the initial state with no warm-up.
    gen_model(80'd0, 80'd0, 0, 4);
    chk("pin_zero_b0", 64'(mdl[0]), 64'd1);
    chk("pin_zero_b1", 64'(mdl[1]), 64'd1);
    chk("pin_zero_b2", 64'(mdl[2]), 64'd1);
    chk("pin_zero_b3", 64'(mdl[3]), 64'd0);
    kk = 80'd1 << 65;
    vv = 80'd1 << 68;
    gen_model(kk, 80'd0, 0, 1);
    chk("pin_key65", 64'(mdl[0]), 64'd0);
    gen_model(80'd0, vv, 0, 1);
    chk("pin_iv68", 64'(mdl[0]), 64'd0);
    gen_model(kk, vv, 0, 1);
    chk("pin_key65_iv68", 64'(mdl[0]), 64'd1);

    key = 80'h0123_4567_89AB_CDEF_1234;
    iv  = 80'hFEDC_BA98_7654_3210_ABCD;
    gen_model(key, iv, 1152, 2048);
    for (int i = 0; i < 64; i++) begin
      src8[i] = 8'h00;
      pt8[i]  = 8'(i * 29 + 7);
    end

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_ks_ready8", 64'(ks8), 64'd0);
    chk("rst_din_ready8", 64'(b8.din_ready), 64'd0);
    chk("rst_dout_valid8", 64'(b8.dout_valid), 64'd0);
    chk("rst_dout_data8", 64'(b8.dout_data), 64'd0);
    chk("rst_ks_ready1", 64'(ks1), 64'd0);
`ifdef TRIVIUM_KS_COUNT_EN
    chk("rst_ks_count8", 64'(cnt8), 64'd0);
`endif
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy8", 64'(busy8), 64'd0);

    // Both widths from the same key/iv, zero input: keystream exposed directly.
    pulse(1'b1, 1'b1);
    measure_init8("first");
    n = 0;
    while (!ks1 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("w1_ready", 64'(ks1), 64'd1);
    cap8.delete(); cap1.delete();
    stream(64, 512);
    chk("cap8_size", 64'(cap8.size()), 64'd64);
    chk("cap1_size", 64'(cap1.size()), 64'd512);
    mism = 0;
    if (cap8.size() == 64 && cap1.size() == 512)
      for (int i = 0; i < 512; i++)
        if (cap8[i/8][i%8] !== cap1[i]) mism++;
    chk("w1_w8_bits_mismatch", 64'(mism), 64'd0);
`ifdef TRIVIUM_KS_COUNT_EN
    chk("ks_count8_64", 64'(cnt8), 64'd64);
    chk("ks_count1_512", 64'(cnt1), 64'd512);
`endif

    // Encrypt then decrypt with a fresh start.
    pulse(1'b1, 1'b0);
`ifdef TRIVIUM_KS_COUNT_EN
    chk("ks_count8_start_clr", 64'(cnt8), 64'd0);
`endif
    measure_init8("enc");
    for (int i = 0; i < 64; i++) src8[i] = pt8[i];
    cap8.delete();
    stream(64, 0);
    chk("ct_size", 64'(cap8.size()), 64'd64);
    for (int i = 0; i < 64; i++) src8[i] = (i < cap8.size()) ? cap8[i] : 8'h00;
    pulse(1'b1, 1'b0);
    measure_init8("dec");
    cap8.delete();
    stream(64, 0);
    chk("pt_size", 64'(cap8.size()), 64'd64);
    mism = 0;
    for (int i = 0; i < 64; i++)
      if (i >= cap8.size() || cap8[i] !== pt8[i]) mism++;
    chk("decrypt_mismatch", 64'(mism), 64'd0);

    // Sink stalls for 10 clocks with a beat waiting behind the held output.
    @(posedge clk); #1;
    b8.dout_ready = 1'b0; b8.din_valid = 1'b1; b8.din_data = 8'h3C;
    @(posedge clk); #1;
    b8.din_data = 8'hC3;
    repeat (10) begin
      @(negedge clk);
      chk("hold_din_ready", 64'(b8.din_ready), 64'd0);
      chk("hold_dout_valid", 64'(b8.dout_valid), 64'd1);
    end
    @(posedge clk); #1;
    b8.dout_ready = 1'b1;
    @(posedge clk); #1;
    b8.din_valid = 1'b0;
    stream(8, 0);

    // Restart mid-RUN with an output pending, then again mid-INIT.
    @(posedge clk); #1;
    b8.dout_ready = 1'b0; b8.din_valid = 1'b1; b8.din_data = 8'h77;
    @(posedge clk); #1;
    b8.din_valid = 1'b0;
    @(negedge clk);
    chk("pending_before_start", 64'(b8.dout_valid), 64'd1);
    pulse(1'b1, 1'b0);
    chk("start_clears_dout_valid", 64'(b8.dout_valid), 64'd0);
    chk("start_sets_busy", 64'(busy8), 64'd1);
    b8.dout_ready = 1'b1;
    repeat (50) @(negedge clk);
    pulse(1'b1, 1'b0);
    measure_init8("restart");
    stream(4, 0);

    // Asynchronous reset while an output beat is pending.
    @(posedge clk); #1;
    b8.dout_ready = 1'b0; b8.din_valid = 1'b1; b8.din_data = 8'h5A;
    @(posedge clk); #1;
    b8.din_valid = 1'b0;
    @(negedge clk);
    chk("pending_before_reset", 64'(b8.dout_valid), 64'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("arst_busy8", 64'(busy8), 64'd0);
    chk("arst_ks_ready8", 64'(ks8), 64'd0);
    chk("arst_din_ready8", 64'(b8.din_ready), 64'd0);
    chk("arst_dout_valid8", 64'(b8.dout_valid), 64'd0);
    chk("arst_dout_data8", 64'(b8.dout_data), 64'd0);
    chk("arst_ks_ready1", 64'(ks1), 64'd0);
`ifdef TRIVIUM_KS_COUNT_EN
    chk("arst_ks_count8", 64'(cnt8), 64'd0);
    chk("arst_ks_count1", 64'(cnt1), 64'd0);
`endif
    #10 reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
